mem_read_arbiter: RTL and testbench

//   Shares one read port of the main memory between instruction fetch (port F) and load/ldu (port D).
//   One transaction is in flight at a time. A request is granted, its doubleword address is presented
//   to memory, the data is captured after MEM_LATENCY cycles and returned to the winner.

---
 rtl/mem_read_arbiter.sv | 78 +++++++
 tb/tb_mem_read_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one memory read port between fetch (F) and load (D), one transaction in flight.
// Load has priority unless fetch has lost STARVE_LIMIT consecutive cycles; flush silences stale fetch data.
module mem_read_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [0:60] f_addr,
  output logic        f_ready,
  output logic        f_resp_valid,
  output logic [0:63] f_resp_data,
  input  logic        d_valid,
  input  logic [0:60] d_addr,
  output logic        d_ready,
  output logic        d_resp_valid,
  output logic [0:63] d_resp_data,
  input  logic        flush,
  output logic [0:60] mem_addr,
  input  logic [0:63] mem_data,
  output logic        busy
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t           r_state;
  logic             r_owner_f;
  logic             r_kill;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [CNT_W-1:0] r_starve;
  logic             w_idle;
  logic             w_f_force;
  logic             w_done;
  logic             w_f_ok;
  assign w_idle    = r_state == S_IDLE && !reset;
  assign w_f_force = f_valid && r_starve >= CNT_W'(STARVE_LIMIT);
  assign f_ready   = w_idle && f_valid && (!d_valid || w_f_force);
  assign d_ready   = w_idle && d_valid && !w_f_force;
  assign w_done    = r_state == S_WAIT && r_lat_cnt == CNT_W'(1);
  // a flush arriving in the capture cycle still cancels the fetch response
  assign w_f_ok    = w_done && r_owner_f && !r_kill && !flush;
  assign busy      = r_state != S_IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner_f    <= 1'b0;
      r_kill       <= 1'b0;
      r_lat_cnt    <= '0;
      r_starve     <= '0;
      mem_addr     <= '0;
      f_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      f_resp_data  <= '0;
      d_resp_data  <= '0;
    end else begin
      f_resp_valid <= w_f_ok;
      d_resp_valid <= w_done && !r_owner_f;
      if (w_f_ok) f_resp_data <= mem_data;
      if (w_done && !r_owner_f) d_resp_data <= mem_data;
      r_starve <= (!f_valid || f_ready) ? '0 : r_starve + CNT_W'(~&r_starve);
      if (f_ready || d_ready) begin
        mem_addr  <= f_ready ? f_addr : d_addr;
        r_owner_f <= f_ready;
        r_lat_cnt <= CNT_W'(MEM_LATENCY);
        r_state   <= S_WAIT;
        r_kill    <= flush && f_ready;
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
        if (w_done) begin
          r_state <= S_IDLE;
          r_kill  <= 1'b0;
        end else if (flush && r_owner_f) begin
          r_kill <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: scenario tasks plus response scoreboard for mem_read_arbiter.
// u_dut runs at MEM_LATENCY=1, u_dut3 at MEM_LATENCY=3; memory is a fixed function of address.
module tb_mem_read_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic f_valid, d_valid, flush;
  logic [0:60] f_addr, d_addr, mem_addr;
  logic f_ready, d_ready, f_resp_valid, d_resp_valid, busy;
  logic [0:63] f_resp_data, d_resp_data, mem_data;
  logic g_f_valid, g_d_valid;
  logic [0:60] g_f_addr, g_d_addr, g_mem_addr;
  logic g_f_ready, g_d_ready, g_f_resp_valid, g_d_resp_valid, g_busy;
  logic [0:63] g_f_resp_data, g_d_resp_data, g_mem_data;
  logic [0:63] f_q[$];
  logic [0:63] d_q[$];
  logic [0:63] fe, de;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  function automatic logic [0:63] mem_fn(input logic [0:60] a);
    return 64'hAABB_CCDD_EEFF_0000 ^ {3'b000, a};
  endfunction
  assign mem_data   = mem_fn(mem_addr);
  assign g_mem_data = mem_fn(g_mem_addr);
  mem_read_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4), .CNT_W(3)) u_dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .flush(flush), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
  );
  mem_read_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .f_valid(g_f_valid), .f_addr(g_f_addr), .f_ready(g_f_ready),
    .f_resp_valid(g_f_resp_valid), .f_resp_data(g_f_resp_data),
    .d_valid(g_d_valid), .d_addr(g_d_addr), .d_ready(g_d_ready),
    .d_resp_valid(g_d_resp_valid), .d_resp_data(g_d_resp_data),
    .flush(1'b0), .mem_addr(g_mem_addr), .mem_data(g_mem_data), .busy(g_busy)
  );
  always @(negedge clk) begin
    total++;
    if (f_ready && d_ready) begin
      bad++;
      $display("FAIL ready_excl: both readies high at %0t", $time);
    end
    if (f_resp_valid) begin
      total++;
      if (f_q.size() == 0) begin
        bad++;
        $display("FAIL f_resp_unexpected: got %h, none expected at %0t", f_resp_data, $time);
      end else begin
        fe = f_q.pop_front();
        if (f_resp_data !== fe) begin
          bad++;
          $display("FAIL f_resp_data: got %h exp %h at %0t", f_resp_data, fe, $time);
        end
      end
    end
    if (d_resp_valid) begin
      total++;
      if (d_q.size() == 0) begin
        bad++;
        $display("FAIL d_resp_unexpected: got %h, none expected at %0t", d_resp_data, $time);
      end else begin
        de = d_q.pop_front();
        if (d_resp_data !== de) begin
          bad++;
          $display("FAIL d_resp_data: got %h exp %h at %0t", d_resp_data, de, $time);
        end
      end
    end
  end
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    f_valid = 0; d_valid = 0; flush = 0; g_f_valid = 0; g_d_valid = 0;
    repeat (n) nxt;
  endtask
  task automatic test_reset;
    reset = 1; f_valid = 1; d_valid = 1; flush = 0; g_f_valid = 1; g_d_valid = 1;
    f_addr = 61'h5; d_addr = 61'h6; g_f_addr = 61'h7; g_d_addr = 61'h9;
    nxt; nxt;
    mid;
    total++;
    if ({f_ready, d_ready, busy, f_resp_valid, d_resp_valid, g_f_ready, g_d_ready, g_busy} !== 8'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b exp 00000000",
               {f_ready, d_ready, busy, f_resp_valid, d_resp_valid, g_f_ready, g_d_ready, g_busy});
    end
    total++;
    if ({f_resp_data, d_resp_data, mem_addr} !== '0) begin
      bad++;
      $display("FAIL reset_data: f=%h d=%h addr=%h exp all 0", f_resp_data, d_resp_data, mem_addr);
    end
    nxt;
    reset = 0;
    idle(2);
  endtask
  task automatic test_single_fetch;
    f_valid = 1; f_addr = 61'h10;
    mid;
    total++;
    if ({f_ready, d_ready} !== 2'b10) begin
      bad++;
      $display("FAIL t1_grant: ready f,d=%b exp 10", {f_ready, d_ready});
    end
    if (f_ready) f_q.push_back(mem_fn(61'h10));
    nxt;
    f_valid = 0;
    mid;
    total++;
    if ({busy, f_resp_valid, mem_addr} !== {1'b1, 1'b0, 61'h10}) begin
      bad++;
      $display("FAIL t1_wait: busy=%b rv=%b addr=%h exp 1 0 10", busy, f_resp_valid, mem_addr);
    end
    nxt;
    mid;
    total++;
    if ({f_resp_valid, busy} !== 2'b10 || f_resp_data !== 64'hAABB_CCDD_EEFF_0010) begin
      bad++;
      $display("FAIL t1_resp: rv=%b busy=%b data=%h exp 1 0 aabbccddeeff0010", f_resp_valid, busy, f_resp_data);
    end
    nxt;
    mid;
    total++;
    if (f_resp_valid !== 1'b0 || f_resp_data !== 64'hAABB_CCDD_EEFF_0010 || mem_addr !== 61'h10) begin
      bad++;
      $display("FAIL t1_hold: rv=%b data=%h addr=%h exp 0 aabbccddeeff0010 10", f_resp_valid, f_resp_data, mem_addr);
    end
    idle(2);
  endtask
  task automatic test_both_valid;
    f_valid = 1; f_addr = 61'h20; d_valid = 1; d_addr = 61'h30;
    mid;
    total++;
    if ({f_ready, d_ready} !== 2'b01) begin
      bad++;
      $display("FAIL t2_d_first: ready f,d=%b exp 01", {f_ready, d_ready});
    end
    if (d_ready) d_q.push_back(mem_fn(61'h30));
    nxt;
    d_valid = 0;
    mid;
    total++;
    if ({f_ready, d_ready, busy} !== 3'b001) begin
      bad++;
      $display("FAIL t2_wait: f_ready,d_ready,busy=%b exp 001", {f_ready, d_ready, busy});
    end
    nxt;
    mid;
    total++;
    if ({f_ready, d_resp_valid} !== 2'b11) begin
      bad++;
      $display("FAIL t2_f_second: f_ready,d_resp_valid=%b exp 11", {f_ready, d_resp_valid});
    end
    if (f_ready) f_q.push_back(mem_fn(61'h20));
    nxt;
    idle(4);
  endtask
  task automatic test_starvation;
    logic [6:0] fexp = 7'b0010000;
    logic [6:0] dexp = 7'b1000101;
    logic gf, gd;
    f_valid = 1; f_addr = 61'h80; d_valid = 1; d_addr = 61'h100;
    for (int k = 0; k < 7; k++) begin
      mid;
      total++;
      if ({f_ready, d_ready} !== {fexp[k], dexp[k]}) begin
        bad++;
        $display("FAIL t3_cycle%0d: ready f,d=%b exp %b", k, {f_ready, d_ready}, {fexp[k], dexp[k]});
      end
      gf = f_ready;
      gd = d_ready;
      if (gf) f_q.push_back(mem_fn(f_addr));
      if (gd) d_q.push_back(mem_fn(d_addr));
      nxt;
      if (gf) f_valid = 0;
      if (gd) d_addr = d_addr + 61'h8;
    end
    idle(4);
  endtask
  task automatic test_back_to_back;
    logic [7:0] dexp = 8'b01010101;
    logic gd;
    d_valid = 1; d_addr = 61'h200;
    for (int k = 0; k < 8; k++) begin
      mid;
      total++;
      if ({f_ready, d_ready} !== {1'b0, dexp[k]}) begin
        bad++;
        $display("FAIL b2b_cycle%0d: ready f,d=%b exp %b", k, {f_ready, d_ready}, {1'b0, dexp[k]});
      end
      gd = d_ready;
      if (gd) d_q.push_back(mem_fn(d_addr));
      nxt;
      if (gd) d_addr = d_addr + 61'h1;
    end
    idle(4);
  endtask
  task automatic test_flush;
    f_valid = 1; f_addr = 61'h40;
    mid;
    total++;
    if (f_ready !== 1'b1) begin
      bad++;
      $display("FAIL t4_grant: f_ready=%b exp 1", f_ready);
    end
    nxt;
    f_valid = 0; flush = 1; d_valid = 1; d_addr = 61'h50;
    mid;
    total++;
    if ({d_ready, busy} !== 2'b01) begin
      bad++;
      $display("FAIL t4_busy: d_ready,busy=%b exp 01", {d_ready, busy});
    end
    nxt;
    flush = 0;
    mid;
    total++;
    if ({f_resp_valid, d_ready} !== 2'b01) begin
      bad++;
      $display("FAIL t4_killed: f_resp_valid,d_ready=%b exp 01", {f_resp_valid, d_ready});
    end
    if (d_ready) d_q.push_back(mem_fn(61'h50));
    nxt;
    d_valid = 0;
    mid;
    nxt;
    mid;
    total++;
    if (d_resp_valid !== 1'b1 || d_resp_data !== mem_fn(61'h50)) begin
      bad++;
      $display("FAIL t4_d_resp: rv=%b data=%h exp 1 %h", d_resp_valid, d_resp_data, mem_fn(61'h50));
    end
    nxt;
    f_valid = 1; f_addr = 61'h48; flush = 1;
    mid;
    total++;
    if (f_ready !== 1'b1) begin
      bad++;
      $display("FAIL t4_grant2: f_ready=%b exp 1", f_ready);
    end
    nxt;
    f_valid = 0; flush = 0;
    mid;
    nxt;
    mid;
    total++;
    if (f_resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL t4_kill_at_grant: f_resp_valid=%b exp 0", f_resp_valid);
    end
    nxt;
    d_valid = 1; d_addr = 61'h58; flush = 1;
    mid;
    if (d_ready) d_q.push_back(mem_fn(61'h58));
    nxt;
    d_valid = 0;
    mid;
    nxt;
    flush = 0;
    mid;
    total++;
    if (d_resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL t4_flush_on_d: d_resp_valid=%b exp 1", d_resp_valid);
    end
    nxt;
    f_valid = 1; f_addr = 61'h68;
    mid;
    if (f_ready) f_q.push_back(mem_fn(61'h68));
    nxt;
    f_valid = 0;
    mid;
    nxt;
    mid;
    total++;
    if (f_resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL t4_kill_cleared: f_resp_valid=%b exp 1", f_resp_valid);
    end
    idle(2);
  endtask
  task automatic test_reset_mid;
    d_valid = 1; d_addr = 61'h60;
    mid;
    total++;
    if (d_ready !== 1'b1) begin
      bad++;
      $display("FAIL t5_grant: d_ready=%b exp 1", d_ready);
    end
    nxt;
    d_valid = 0; reset = 1;
    mid;
    total++;
    if ({busy, f_ready, d_ready} !== 3'b100) begin
      bad++;
      $display("FAIL t5_in_wait: busy,f_ready,d_ready=%b exp 100", {busy, f_ready, d_ready});
    end
    nxt;
    d_valid = 1; f_valid = 1;
    mid;
    total++;
    if ({busy, f_ready, d_ready, d_resp_valid} !== 4'b0000 || d_resp_data !== '0 || mem_addr !== '0) begin
      bad++;
      $display("FAIL t5_reset: busy,fr,dr,rv=%b data=%h addr=%h exp 0000 0 0",
               {busy, f_ready, d_ready, d_resp_valid}, d_resp_data, mem_addr);
    end
    nxt;
    reset = 0; f_valid = 0;
    mid;
    total++;
    if ({d_resp_valid, d_ready} !== 2'b01) begin
      bad++;
      $display("FAIL t5_resume: d_resp_valid,d_ready=%b exp 01", {d_resp_valid, d_ready});
    end
    if (d_ready) d_q.push_back(mem_fn(61'h60));
    nxt;
    idle(4);
  endtask
  task automatic test_latency3;
    g_d_valid = 1; g_d_addr = 61'h70;
    mid;
    total++;
    if (g_d_ready !== 1'b1) begin
      bad++;
      $display("FAIL t6_grant: d_ready=%b exp 1", g_d_ready);
    end
    nxt;
    g_d_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      mid;
      total++;
      if ({g_busy, g_d_resp_valid, g_d_ready} !== 3'b100) begin
        bad++;
        $display("FAIL t6_wait%0d: busy,rv,ready=%b exp 100", k, {g_busy, g_d_resp_valid, g_d_ready});
      end
      nxt;
    end
    g_f_valid = 1; g_f_addr = 61'h78;
    mid;
    total++;
    if ({g_busy, g_d_resp_valid, g_f_ready} !== 3'b011 || g_d_resp_data !== mem_fn(61'h70)) begin
      bad++;
      $display("FAIL t6_resp: busy,rv,f_ready=%b data=%h exp 011 %h",
               {g_busy, g_d_resp_valid, g_f_ready}, g_d_resp_data, mem_fn(61'h70));
    end
    nxt;
    g_f_valid = 0;
    mid;
    total++;
    if (g_d_resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL t6_pulse: d_resp_valid=%b exp 0", g_d_resp_valid);
    end
    repeat (3) nxt;
    mid;
    total++;
    if (g_f_resp_valid !== 1'b1 || g_f_resp_data !== mem_fn(61'h78)) begin
      bad++;
      $display("FAIL t6_f_resp: rv=%b data=%h exp 1 %h", g_f_resp_valid, g_f_resp_data, mem_fn(61'h78));
    end
    idle(2);
  endtask
  initial begin
    test_reset;
    test_single_fetch;
    test_both_valid;
    test_starvation;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_latency3;
    total++;
    if (f_q.size() != 0 || d_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending f=%0d d=%0d exp 0 0", f_q.size(), d_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
